// File: rtl/uart_pkg.sv
// Constants shared by the UART Tx/Rx blocks: default word width and Tx hold depth.
package uart_pkg;

  localparam int unsigned UART_DATA_W   = 8;
  localparam int unsigned TX_FIFO_DEPTH = 4;

endpackage : uart_pkg

// File: rtl/tx_hold_fifo_if.sv
// Producer/consumer bundle for the Tx hold FIFO; master is the producer/consumer side, slave is the FIFO.
interface tx_hold_fifo_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = TX_FIFO_DEPTH
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] data_in;
  logic              load_req;
  logic              load_ack;
  logic              done_flag;
  logic [DATA_W-1:0] reg_in;
  logic              reg_valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              clr_err;

  modport master (
    output data_in, load_req, done_flag, clr_err,
    input  load_ack, reg_in, reg_valid, full, empty, count, overflow, underflow
  );

  modport slave (
    input  data_in, load_req, done_flag, clr_err,
    output load_ack, reg_in, reg_valid, full, empty, count, overflow, underflow
  );

endinterface : tx_hold_fifo_if

// File: rtl/tx_hold_fifo.sv
// First-word fall-through hold FIFO between the Tx word source and the Tx engine,
// with registered occupancy flags and sticky overflow/underflow error flags.
module tx_hold_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W = UART_DATA_W,
  parameter int unsigned DEPTH  = TX_FIFO_DEPTH
) (
  input  logic           clk,
  input  logic           rst,
  tx_hold_fifo_if.slave  bus
);

  localparam int unsigned ADDR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W  = ADDR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] rd_ptr_inc;
  logic [CNT_W-1:0]  count_q;
  logic [CNT_W-1:0]  count_nxt;
  logic              full_q;
  logic              empty_q;
  logic [DATA_W-1:0] reg_in_q;
  logic [DATA_W-1:0] head_nxt;
  logic              ovf_q;
  logic              unf_q;
  logic              push;
  logic              pop;

  // Acceptance depends only on registered flags, never on a same-cycle pop.
  assign push       = bus.load_req & ~full_q;
  assign pop        = bus.done_flag & ~empty_q;
  assign rd_ptr_inc = rd_ptr + ADDR_W'(1);

  always_comb begin
    count_nxt = count_q;
    unique case ({push, pop})
      2'b10:   count_nxt = count_q + CNT_W'(1);
      2'b01:   count_nxt = count_q - CNT_W'(1);
      default: count_nxt = count_q;
    endcase
  end

  // Head word seen after this edge; when the pop empties the FIFO the popped word is kept.
  always_comb begin
    head_nxt = reg_in_q;
    if (pop) begin
      if (count_q > CNT_W'(1)) begin
        head_nxt = mem[rd_ptr_inc];
      end else if (push) begin
        head_nxt = bus.data_in;
      end
    end else if (push && empty_q) begin
      head_nxt = bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      reg_in_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop)  rd_ptr <= rd_ptr_inc;
      count_q  <= count_nxt;
      full_q   <= (count_nxt == CNT_W'(DEPTH));
      empty_q  <= (count_nxt == '0);
      reg_in_q <= head_nxt;
      // Set wins over a coincident clear.
      ovf_q    <= (bus.load_req & full_q)   | (ovf_q & ~bus.clr_err);
      unf_q    <= (bus.done_flag & empty_q) | (unf_q & ~bus.clr_err);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= bus.data_in;
    end
  end

  assign bus.load_ack  = push & ~rst;
  assign bus.reg_in    = reg_in_q;
  assign bus.reg_valid = ~empty_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;
  assign bus.count     = count_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule : tx_hold_fifo
